// File: rtl/coin_pulse_pkg.sv
// Shared types for the multi-channel coin pulse generator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package coin_pulse_pkg;

    // Per-channel pulse sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Frame counts are measured in vblank rising edges
    typedef logic [7:0] frame_t;

endpackage

// File: rtl/coin_pulse_chan.sv
// One coin channel: release detector, pending-coin counter and PULSE/GAP sequencer.
// Latency: a release reaches the pulse output 2 clk later when the channel is idle.
// Backpressure: up to QUEUE_DEPTH coins wait; further coins are dropped and flagged sticky.
// Option: COIN_PULSE_LOCKOUT_EN makes i_lockout discard new coins on this channel.
module coin_pulse_chan
    import coin_pulse_pkg::*;
#(
    parameter int PULSE_FRAMES = 4,
    parameter int GAP_FRAMES   = 4,
    parameter int QUEUE_DEPTH  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_button,
    input  logic i_lockout,
    output logic o_pulse,
    output logic o_overflow
);

    localparam int                PEND_W  = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PEND_W-1:0] DEPTH_V = PEND_W'(QUEUE_DEPTH);
    localparam frame_t            PULSE_F = frame_t'(PULSE_FRAMES);
    localparam frame_t            GAP_F   = frame_t'(GAP_FRAMES);

    logic              r_button;
    logic [PEND_W-1:0] r_pending;
    logic              r_overflow;
    state_t            r_state;
    frame_t            r_frames;
    logic              r_pulse;

    logic w_release;
    logic w_coin;
    logic w_take;
    logic w_full;
    logic w_accept;

    assign w_release = r_button & ~i_button;

`ifdef COIN_PULSE_LOCKOUT_EN
    assign w_coin = w_release & ~i_lockout;
`else
    assign w_coin = w_release;
    logic w_unused_lockout;
    assign w_unused_lockout = i_lockout;
`endif

    // A pending coin is consumed in the same cycle the sequencer leaves IDLE
    assign w_take   = (r_state == IDLE) && (r_pending != '0);
    assign w_full   = (r_pending == DEPTH_V);
    // A coin arriving while the queue is full but a slot is being freed is kept
    assign w_accept = w_coin && (!w_full || w_take);

    // Registered copy of the switch; cleared by reset so a held button is not a release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_button <= 1'b0;
        else       r_button <= i_button;
    end

    // Pending-coin count and sticky drop flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept && !w_take)      r_pending <= r_pending + 1'b1;
            else if (!w_accept && w_take) r_pending <= r_pending - 1'b1;
            if (w_coin && !w_accept)      r_overflow <= 1'b1;
        end
    end

    // Pulse sequencer; the entry cycle ignores any tick so each pulse gets full frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_frames <= '0;
            r_pulse  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state  <= PULSE;
                        r_frames <= PULSE_F;
                        r_pulse  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (i_tick && (r_frames != '0)) begin
                        if (r_frames == 8'd1) begin
                            r_pulse <= 1'b0;
                            if (GAP_FRAMES == 0) begin
                                r_state  <= IDLE;
                                r_frames <= '0;
                            end else begin
                                r_state  <= GAP;
                                r_frames <= GAP_F;
                            end
                        end else begin
                            r_frames <= r_frames - 8'd1;
                        end
                    end
                end
                GAP: begin
                    if (r_frames == '0) begin
                        r_state <= IDLE;
                    end else if (i_tick) begin
                        r_frames <= r_frames - 8'd1;
                        if (r_frames == 8'd1) r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_frames <= '0;
                    r_pulse  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pulse    = r_pulse;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/coin_pulse_multi.sv
// Multi-channel coin pulse generator: queues coin releases and replays them as frame-timed pulses.
// Latency: 2 clk from a release to pulse on an idle channel; pulses last PULSE_FRAMES vblank edges.
// Backpressure: QUEUE_DEPTH coins queue per channel; excess coins set a sticky overflow bit.
// Option: COIN_PULSE_LOCKOUT_EN enables per-channel coin rejection via coin_lockout.
module coin_pulse_multi
    import coin_pulse_pkg::*;
#(
    parameter int NUM_COINS    = 2,
    parameter int PULSE_FRAMES = 4,
    parameter int GAP_FRAMES   = 4,
    parameter int QUEUE_DEPTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vblank,
    input  logic [NUM_COINS-1:0] button,
    input  logic [NUM_COINS-1:0] coin_lockout,
    output logic [NUM_COINS-1:0] pulse,
    output logic [NUM_COINS-1:0] overflow
);

    logic r_vblank;
    logic w_tick;

    // Registered vblank for the shared frame-tick edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_vblank <= 1'b0;
        else       r_vblank <= vblank;
    end

    assign w_tick = vblank & ~r_vblank;

    for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_chan
        coin_pulse_chan #(
            .PULSE_FRAMES (PULSE_FRAMES),
            .GAP_FRAMES   (GAP_FRAMES),
            .QUEUE_DEPTH  (QUEUE_DEPTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_tick     (w_tick),
            .i_button   (button[gi]),
            .i_lockout  (coin_lockout[gi]),
            .o_pulse    (pulse[gi]),
            .o_overflow (overflow[gi])
        );
    end

endmodule

// File: tb/tb_coin_pulse_multi.sv
// Scoreboard bench for coin_pulse_multi at default parameters.
// Expected pulses (length in frame ticks, gap before) are queued per channel;
// a negedge monitor measures each pulse and pops/compares on its falling edge.
module tb_coin_pulse_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       vblank;
    logic [1:0] button;
    logic [1:0] coin_lockout;
    logic [1:0] pulse;
    logic [1:0] overflow;

    coin_pulse_multi dut (
        .clk          (clk),
        .reset        (reset),
        .vblank       (vblank),
        .button       (button),
        .coin_lockout (coin_lockout),
        .pulse        (pulse),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int gap;   // -1: gap not checked
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;
    logic vb_q;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic void exp_push(input int c, input int len, input int gap);
        exp_t e;
        e.len = len;
        e.gap = gap;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press then release the channels in m
    task automatic rel(input logic [1:0] m);
        button = button | m;
        cyc(2);
        button = button & ~m;
        cyc(2);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || pulse != 2'b00) && k < 5000) begin
            cyc(1);
            k++;
        end
        check({name, "_drained"}, int'(k < 5000), 1);
        cyc(96);
    endtask

    task automatic wait_pulse(input int c, input logic v, input string name);
        int k;
        k = 0;
        while (pulse[c] != v && k < 2000) begin
            cyc(1);
            k++;
        end
        check({name, "_wait"}, int'(k < 2000), 1);
    endtask

    task automatic wait_tick(input int t, input string name);
        int k;
        k = 0;
        while (tick_cnt < t && k < 2000) begin
            cyc(1);
            k++;
        end
        check({name, "_tick_wait"}, int'(k < 2000), 1);
    endtask

    // Frame generator: 24-clk frames, vblank high for 6 clk
    initial begin
        vblank = 1'b0;
        cyc(7);
        forever begin
            vblank = 1'b1;
            cyc(6);
            vblank = 1'b0;
            cyc(18);
        end
    end

    // Reference frame tick counter, sampled exactly as the DUT sees vblank
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            vb_q <= 1'b0;
        end else begin
            vb_q <= vblank;
            if (vblank && !vb_q) tick_cnt <= tick_cnt + 1;
        end
    end

    // Monitor: measure each pulse, compare against the channel's expectation queue
    logic [1:0] p_q = 2'b00;
    int rise_t[2];
    int fall_t[2] = '{-1000, -1000};

    always @(negedge clk) begin : mon
        exp_t e;
        int   qs;
        for (int c = 0; c < 2; c++) begin
            if (pulse[c] && !p_q[c]) begin
                rise_t[c] <= tick_cnt;
            end else if (!pulse[c] && p_q[c]) begin
                qs = (c == 0) ? q0.size() : q1.size();
                check($sformatf("pulse_expected_ch%0d", c), int'(qs > 0), 1);
                if (qs > 0) begin
                    e = (c == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("pulse_len_ch%0d", c), tick_cnt - rise_t[c], e.len);
                    if (e.gap >= 0)
                        check($sformatf("gap_len_ch%0d", c), rise_t[c] - fall_t[c], e.gap);
                end
                fall_t[c] <= tick_cnt;
            end
        end
        p_q <= pulse;
    end

    initial begin
        int f;
        button       = 2'b00;
        coin_lockout = 2'b00;
        reset        = 1'b1;
        cyc(3);
        check("reset_pulse", pulse, 0);
        check("reset_overflow", overflow, 0);
        reset = 1'b0;
        cyc(3);

        // Single coin on channel 0
        exp_push(0, 4, -1);
        rel(2'b01);
        check("single_pulse_on", pulse, 2'b01);
        drain("single");

        // Burst of three coins
        exp_push(0, 4, -1);
        exp_push(0, 4, 4);
        exp_push(0, 4, 4);
        repeat (3) rel(2'b01);
        drain("burst");
        check("burst_overflow", overflow, 2'b00);

        // Five coins: one issued at once, three queued, one dropped
        exp_push(0, 4, -1);
        repeat (3) exp_push(0, 4, 4);
        repeat (5) rel(2'b01);
        drain("ovf");
        check("ovf_flag", overflow, 2'b01);

        // Both channels together, then a release landing on the PULSE entry cycle
        exp_push(0, 4, -1);
        exp_push(0, 4, 4);
        exp_push(0, 4, 4);
        exp_push(1, 4, -1);
        rel(2'b11);
        check("lockstep", pulse, 2'b11);
        rel(2'b01);
        button[0] = 1'b1;
        wait_pulse(0, 1'b0, "first_fall");
        f = tick_cnt;
        wait_tick(f + 4, "gap_end");
        button[0] = 1'b0;
        cyc(2);
        check("entry_with_coin", pulse[0], 1);
        drain("simul");
        check("ovf_sticky", overflow, 2'b01);

        // Reset during the second tick of a pulse; button[1] held through reset
        exp_push(0, 1, -1);
        rel(2'b01);
        rel(2'b01);
        button[1] = 1'b1;
        wait_pulse(0, 1'b1, "rst_rise");
        f = tick_cnt;
        wait_tick(f + 1, "rst_tick");
        reset = 1'b1;
        #1;
        check("rst_pulse_drop", pulse, 0);
        check("rst_overflow_clr", overflow, 0);
        cyc(3);
        reset = 1'b0;
        cyc(240);
        check("rst_no_follow", pulse, 0);
        check("rst_queue_seen", q0.size(), 0);
        exp_push(1, 4, -1);
        button[1] = 1'b0;
        drain("held_btn");

        // Lockout on channel 0
        coin_lockout = 2'b01;
`ifdef COIN_PULSE_LOCKOUT_EN
        exp_push(1, 4, -1);
        rel(2'b11);
        check("lockout_pulse", pulse, 2'b10);
`else
        exp_push(0, 4, -1);
        exp_push(1, 4, -1);
        rel(2'b11);
        check("lockout_pulse", pulse, 2'b11);
`endif
        drain("lockout");
        check("lockout_overflow", overflow, 2'b00);
        coin_lockout = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coin_pulse_multi.md
COIN_PULSE_MULTI -- requirements
Module: coin_pulse_multi

Interface
REQ-001 Parameter NUM_COINS, default 2: number of independent coin channels, range 1..8.
REQ-002 Parameter PULSE_FRAMES, default 4: pulse length in vblank rising edges, range 1..255.
REQ-003 Parameter GAP_FRAMES, default 4: minimum low time between queued pulses in vblank rising edges, range 0..255.
REQ-004 Parameter QUEUE_DEPTH, default 3: maximum pending coins per channel, range 1..15.
REQ-005 clk  input  1  single system clock; all logic is synchronous to its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 vblank  input  1  frame timing; each 0->1 transition seen on clk is one frame tick.
REQ-008 button  input  NUM_COINS  raw coin switches, active-high, one bit per channel.
REQ-009 coin_lockout  input  NUM_COINS  per-channel coin rejection; honoured only per REQ-030.
REQ-010 pulse  output  NUM_COINS  registered coin pulses to the game core, active-high.
REQ-011 overflow  output  NUM_COINS  sticky flag per channel: a coin was dropped because the queue was full.

Function
REQ-012 Each channel shall register button and vblank once; edges are computed from the current input and its registered copy.
REQ-013 A coin event shall be a button 1->0 transition (release), detected in the cycle where button=0 and the previous button=1.
REQ-014 The frame tick shall be vblank=1 with previous vblank=0, and shall be shared by all channels.
REQ-015 Each channel shall keep a pending counter of width clog2(QUEUE_DEPTH+1), reset to 0.
REQ-016 A coin event shall increment pending in the next cycle if pending < QUEUE_DEPTH; otherwise pending is unchanged and overflow is set.
REQ-017 Per-channel FSM states: IDLE, PULSE, GAP; reset state is IDLE.
REQ-018 IDLE->PULSE in the cycle after pending>0; pending decrements on that transition, and the frame counter loads PULSE_FRAMES.
REQ-019 In PULSE, each frame tick shall decrement the frame counter; when it reaches 0, go to GAP and load GAP_FRAMES, or go to IDLE if GAP_FRAMES=0.
REQ-020 In GAP, each frame tick shall decrement the frame counter; at 0 go to IDLE.
REQ-021 pulse[i] shall be 1 exactly while channel i is in PULSE; it is a registered output with no combinational path from inputs.
REQ-022 If a coin event and a PULSE entry occur in the same cycle, pending shall net to unchanged; no event is lost or double-counted.
REQ-023 A frame tick in the same cycle as PULSE entry shall not count toward that pulse, so every pulse lasts PULSE_FRAMES full ticks.
REQ-024 Frame counters shall be 8 bits and shall never wrap below 0.
REQ-025 Channels shall be fully independent; simultaneous events on all channels shall each be queued.
REQ-026 overflow[i] shall clear only on reset.

Reset
REQ-027 Asserting reset at any time, including mid-pulse, shall force pulse=0, overflow=0, pending=0, state IDLE and the registered input copies to 0.
REQ-028 A button held at 1 through reset release shall not produce a coin event until a later 1->0 transition is seen after the registered copy has captured 1.

Configuration
REQ-029 Macro COIN_PULSE_LOCKOUT_EN selects lockout support.
REQ-030 With the macro defined, a coin event on a channel whose coin_lockout bit is 1 shall be discarded: no queue change and no overflow; pulses already queued still complete.
REQ-031 Without the macro, the coin_lockout port shall remain present and be ignored.

Structure
REQ-032 Package coin_pulse_pkg shall hold the FSM state enum (IDLE/PULSE/GAP) and the 8-bit frame-count typedef.
REQ-033 Per-channel logic shall be sub-module coin_pulse_chan, instantiated NUM_COINS times by a generate loop; the vblank edge detector stays in the top level.

Verification
REQ-034 Single coin, defaults: press and release button[0] -> pulse[0] high for exactly 4 frame ticks, then low; pulse[1] stays 0.
REQ-035 Burst: 3 releases on channel 0 within one frame -> 3 pulses, each 4 ticks high, separated by 4 ticks low; overflow[0]=0.
REQ-036 Overflow: 5 releases within one frame with QUEUE_DEPTH=3 -> 4 pulses (1 issued immediately plus 3 queued), and overflow[0]=1 until reset.
REQ-037 Simultaneous events: both channels released in the same cycle, plus a release coinciding with PULSE entry -> both channels pulse in lockstep and no coin is lost.
REQ-038 Reset during the 2nd tick of a pulse -> pulse drops immediately to 0, the queue is empty, and no pulse follows.
REQ-039 With COIN_PULSE_LOCKOUT_EN and coin_lockout=2'b01: releases on both channels -> only pulse[1] fires.
